apb_master_arbiter: RTL and testbench



---
 rtl/apb_arb_pkg.sv | 27 ++
 rtl/apb_master_arbiter_rr_arbiter.sv | 33 +++
 rtl/apb_master_arbiter.sv | 157 +++++++++++++++
 tb/tb_apb_master_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, default parameter values, and the
// timeout counter width helper. The optional timeout feature is
// controlled by the APB_TIMEOUT_EN macro in apb_master_arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 16;

  // Timeout counter width is clog2(TIMEOUT), floored at one bit.
  function automatic int to_cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker over NREQ request lines.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the pick.
//
// Ports: req_i (request vector), ptr_i (index of the last grant),
//        gnt_idx_o (winner index), any_req_o (at least one request set).
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            any_req_o
);

  logic [IW-1:0] cand;

  // Search upward from ptr_i+1, wrapping modulo NREQ; the first hit wins.
  always_comb begin
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_i) + i) % NREQ);
      if (!any_req_o && req_i[cand]) begin
        any_req_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NREQ req/ack requesters (round robin).
// Latency: req sampled at edge 0, SETUP edge 1, ACCESS edge 2; ack high for the one DONE cycle.
// Backpressure: pclk_en gates every APB phase; pready stretches ACCESS (optionally bounded).
//
// Ports: hclk/hresetn clock and async active-low reset; pclk_en APB enable;
//        req/req_write/req_addr/req_wdata requester side (flattened per index);
//        ack/rsp_rdata/rsp_err completion side; paddr/psel/penable/pwrite/
//        pwdata/prdata/pready/pslverr APB master side.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT enabled
//           wait cycles; without it ACCESS waits for pready indefinitely.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              pclk_en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic [AW-1:0]     paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DW-1:0]     pwdata,
  input  logic [DW-1:0]     prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   gnt_q;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [AW-1:0]   paddr_q;
  logic            psel_q;
  logic            penable_q;
  logic            pwrite_q;
  logic [DW-1:0]   pwdata_q;

  logic [IW-1:0]   arb_idx;
  logic            arb_any;

`ifdef APB_TIMEOUT_EN
  localparam int            TCW     = to_cnt_w(TIMEOUT);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);
  logic [TCW-1:0] to_cnt_q;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_idx_o (arb_idx),
    .any_req_o (arb_any)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      gnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pclk_en && arb_any) begin
            gnt_q    <= arb_idx;
            ptr_q    <= arb_idx;
            paddr_q  <= req_addr[int'(arb_idx)*AW +: AW];
            pwrite_q <= req_write[arb_idx];
            pwdata_q <= req_wdata[int'(arb_idx)*DW +: DW];
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          if (pclk_en) begin
            penable_q <= 1'b1;
            state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
          end
        end
        ACCESS: begin
          if (pclk_en) begin
            if (pready) begin
              psel_q       <= 1'b0;
              penable_q    <= 1'b0;
              rdata_q      <= pwrite_q ? '0 : prdata;
              err_q        <= pslverr;
              ack_q[gnt_q] <= 1'b1;
              state_q      <= DONE;
            end
`ifdef APB_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
              // Abort: report an error with zero data; a late pready is never seen.
              psel_q       <= 1'b0;
              penable_q    <= 1'b0;
              rdata_q      <= '0;
              err_q        <= 1'b1;
              ack_q[gnt_q] <= 1'b1;
              state_q      <= DONE;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
          end
        end
        DONE: begin
          // One hclk cycle regardless of pclk_en; it also keeps the
          // requester's stale req from being sampled while ack is high.
          ack_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                 hclk = 1'b0;
  logic                 hresetn;
  logic                 pclk_en;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic [AW-1:0]        paddr;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [DW-1:0]        pwdata;
  logic [DW-1:0]        prdata;
  logic                 pready;
  logic                 pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 hclk = ~hclk;

  apb_master_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
`ifdef APB_TIMEOUT_EN
    ,
    .TIMEOUT (4)
`endif
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .pclk_en   (pclk_en),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // Waits (bounded) for an ack pulse; reports negedges waited.
  task automatic wait_ack(input int max_cyc, output logic found,
                          output logic [NREQ-1:0] a, output int cyc);
    found = 1'b0;
    a     = '0;
    cyc   = 0;
    while (!found && cyc < max_cyc) begin
      @(negedge hclk);
      cyc++;
      if (ack !== '0) begin
        found = 1'b1;
        a     = ack;
      end
    end
  endtask

  task automatic wait_pen(output logic seen);
    int c;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 10) begin
      @(negedge hclk);
      c++;
      if (penable === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge hclk);
    hresetn = 1'b0;
    req     = '0;
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    n_checks++;
    if ({psel, penable, pwrite} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {psel, penable, pwrite});
    else n_pass++;
    n_checks++;
    if (ack !== 4'b0000) $display("FAIL reset_ack: got %b expected 0000", ack);
    else n_pass++;
    n_checks++;
    if ({rsp_rdata, rsp_err} !== '0) $display("FAIL reset_rsp: got %h/%b expected 0/0", rsp_rdata, rsp_err);
    else n_pass++;
    n_checks++;
    if ({paddr, pwdata} !== '0) $display("FAIL reset_bus: got %h/%h expected 0/0", paddr, pwdata);
    else n_pass++;
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_single_read();
    req_addr[2*AW +: AW] = 32'h4000_0010;
    req_write[2]         = 1'b0;
    prdata               = 32'hDEAD_BEEF;
    pready               = 1'b1;
    pslverr              = 1'b0;
    req[2]               = 1'b1;
    @(negedge hclk);
    n_checks++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 32'h4000_0010})
      $display("FAIL read_setup: got psel=%b pen=%b pw=%b paddr=%h expected 1 0 0 40000010", psel, penable, pwrite, paddr);
    else n_pass++;
    @(negedge hclk);
    n_checks++;
    if ({psel, penable, ack} !== {2'b11, 4'b0000}) $display("FAIL read_access: got psel=%b pen=%b ack=%b expected 1 1 0000", psel, penable, ack);
    else n_pass++;
    @(negedge hclk);
    n_checks++;
    if ({ack, psel, penable} !== {4'b0100, 2'b00}) $display("FAIL read_ack: got ack=%b psel=%b pen=%b expected 0100 0 0", ack, psel, penable);
    else n_pass++;
    n_checks++;
    if ({rsp_rdata, rsp_err} !== {32'hDEAD_BEEF, 1'b0}) $display("FAIL read_rsp: got %h/%b expected deadbeef/0", rsp_rdata, rsp_err);
    else n_pass++;
    req[2] = 1'b0;
    prdata = 32'h0;
    @(negedge hclk);
    n_checks++;
    if (ack !== 4'b0000) $display("FAIL read_ack_width: got %b expected 0000", ack);
    else n_pass++;
    n_checks++;
    if ({rsp_rdata, paddr} !== {32'hDEAD_BEEF, 32'h4000_0010}) $display("FAIL read_hold: got %h/%h expected deadbeef/40000010", rsp_rdata, paddr);
    else n_pass++;
    @(negedge hclk);
    n_checks++;
    if (psel !== 1'b0) $display("FAIL read_no_resample: got psel=%b expected 0", psel);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic            found;
    logic [NREQ-1:0] a;
    logic [NREQ-1:0] exp_a;
    int              cyc;
    int              ord[4];
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = 32'h100 * i;
      req_write[i]         = 1'b0;
    end
    pready = 1'b1;
    req    = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, found, a, cyc);
      exp_a = 4'b0001 << k;
      n_checks++;
      if (!found || a !== exp_a) $display("FAIL rr_all_%0d: got %b found=%b expected %b", k, a, found, exp_a);
      else n_pass++;
      req = req & ~a;
    end
    ord = '{0, 3, 0, 3};
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, found, a, cyc);
      exp_a = 4'b0001 << ord[k];
      n_checks++;
      if (!found || a !== exp_a) $display("FAIL rr_pair_%0d: got %b found=%b expected %b", k, a, found, exp_a);
      else n_pass++;
    end
    req = '0;
    repeat (2) @(negedge hclk);
  endtask

  task automatic test_back_to_back();
    logic            found;
    logic [NREQ-1:0] a;
    int              cyc;
    req = 4'b0010;
    wait_ack(20, found, a, cyc);
    n_checks++;
    if (!found || a !== 4'b0010) $display("FAIL b2b_first: got %b found=%b expected 0010", a, found);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      wait_ack(20, found, a, cyc);
      n_checks++;
      if (!found || cyc !== 4) $display("FAIL b2b_period_%0d: got %0d cycles found=%b expected 4", k, cyc, found);
      else n_pass++;
    end
    req = '0;
    repeat (2) @(negedge hclk);
  endtask

  task automatic test_wait_err();
    logic seen;
    req_addr[1*AW +: AW]  = 32'h8;
    req_wdata[1*DW +: DW] = 32'h1234_5678;
    req_write[1]          = 1'b1;
    prdata                = 32'hFFFF_FFFF;
    pready                = 1'b0;
    pslverr               = 1'b1;
    req                   = 4'b0010;
    wait_pen(seen);
    n_checks++;
    if (!seen) $display("FAIL werr_access: got penable never high expected high");
    else n_pass++;
    for (int w = 0; w < 3; w++) begin
      @(negedge hclk);
      n_checks++;
      if ({psel, penable, pwrite, paddr, pwdata, ack} !== {3'b111, 32'h8, 32'h1234_5678, 4'b0000})
        $display("FAIL werr_stable_%0d: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h ack=%b expected 1 1 1 8 12345678 0000",
                 w, psel, penable, pwrite, paddr, pwdata, ack);
      else n_pass++;
    end
    pready = 1'b1;
    @(negedge hclk);
    n_checks++;
    if ({ack, rsp_err, rsp_rdata} !== {4'b0010, 1'b1, 32'h0})
      $display("FAIL werr_ack: got ack=%b err=%b rdata=%h expected 0010 1 0", ack, rsp_err, rsp_rdata);
    else n_pass++;
    req     = '0;
    pslverr = 1'b0;
    repeat (2) @(negedge hclk);
  endtask

  task automatic test_pclk_half();
    logic en_prev;
    logic psel_prev;
    logic pen_prev;
    int   ack_cyc;
    req_addr[3*AW +: AW]  = 32'h30;
    req_wdata[3*DW +: DW] = 32'hA5A5_0003;
    req_write[3]          = 1'b1;
    pready                = 1'b1;
    pclk_en               = 1'b1;
    req                   = 4'b1000;
    ack_cyc               = 0;
    en_prev               = pclk_en;
    psel_prev             = psel;
    pen_prev              = penable;
    for (int c = 0; c < 30; c++) begin
      @(negedge hclk);
      if (!en_prev) begin
        n_checks++;
        if ({psel, penable} !== {psel_prev, pen_prev})
          $display("FAIL half_gated_%0d: got psel=%b pen=%b expected %b %b", c, psel, penable, psel_prev, pen_prev);
        else n_pass++;
      end
      if (ack !== '0) begin
        ack_cyc++;
        n_checks++;
        if (ack !== 4'b1000) $display("FAIL half_ack_idx: got %b expected 1000", ack);
        else n_pass++;
        req = '0;
      end
      psel_prev = psel;
      pen_prev  = penable;
      pclk_en   = ~pclk_en;
      en_prev   = pclk_en;
    end
    n_checks++;
    if (ack_cyc !== 1) $display("FAIL half_ack_width: got %0d ack cycles expected 1", ack_cyc);
    else n_pass++;
    pclk_en = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_reset_mid();
    logic            seen;
    logic            found;
    logic [NREQ-1:0] a;
    int              cyc;
    req_write[2] = 1'b0;
    pready       = 1'b0;
    req          = 4'b0100;
    wait_pen(seen);
    n_checks++;
    if (!seen) $display("FAIL rmid_access: got penable never high expected high");
    else n_pass++;
    hresetn = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, ack} !== {2'b00, 4'b0000}) $display("FAIL rmid_clear: got psel=%b pen=%b ack=%b expected 0 0 0000", psel, penable, ack);
    else n_pass++;
    @(negedge hclk);
    hresetn = 1'b1;
    req     = 4'b0011;
    pready  = 1'b1;
    wait_ack(20, found, a, cyc);
    n_checks++;
    if (!found || a !== 4'b0001) $display("FAIL rmid_first: got %b found=%b expected 0001", a, found);
    else n_pass++;
    req[0] = 1'b0;
    wait_ack(20, found, a, cyc);
    n_checks++;
    if (!found || a !== 4'b0010) $display("FAIL rmid_second: got %b found=%b expected 0010", a, found);
    else n_pass++;
    req = '0;
    repeat (2) @(negedge hclk);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    logic seen;
    req_write[0] = 1'b0;
    prdata       = 32'h5555_AAAA;
    pready       = 1'b0;
    pslverr      = 1'b0;
    req          = 4'b0001;
    wait_pen(seen);
    n_checks++;
    if (!seen) $display("FAIL to_access: got penable never high expected high");
    else n_pass++;
    for (int w = 0; w < 3; w++) begin
      @(negedge hclk);
      n_checks++;
      if ({penable, ack} !== {1'b1, 4'b0000}) $display("FAIL to_wait_%0d: got pen=%b ack=%b expected 1 0000", w, penable, ack);
      else n_pass++;
    end
    @(negedge hclk);
    n_checks++;
    if ({ack, psel, penable, rsp_err, rsp_rdata} !== {4'b0001, 3'b001, 32'h0})
      $display("FAIL to_abort: got ack=%b psel=%b pen=%b err=%b rdata=%h expected 0001 0 0 1 0", ack, psel, penable, rsp_err, rsp_rdata);
    else n_pass++;
    req    = '0;
    pready = 1'b1;
    @(negedge hclk);
    n_checks++;
    if ({ack, psel, rsp_err, rsp_rdata} !== {4'b0000, 1'b0, 1'b1, 32'h0})
      $display("FAIL to_late_ready: got ack=%b psel=%b err=%b rdata=%h expected 0000 0 1 0", ack, psel, rsp_err, rsp_rdata);
    else n_pass++;
    @(negedge hclk);
    n_checks++;
    if (psel !== 1'b0) $display("FAIL to_idle: got psel=%b expected 0", psel);
    else n_pass++;
  endtask
`endif

  initial begin
    hresetn   = 1'b0;
    pclk_en   = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_wait_err();
    test_pclk_half();
    test_reset_mid();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
